uart_packet_parser: RTL and testbench
=====================================

// Module: uart_packet_parser
// PURPOSE
// Parametrised packet front-end between the UART byte receiver and the ALU/echo datapath.
// Parses the header: opcode, reserved byte, 16-bit little-endian length.
// Assembles up to MAX_OPERANDS little-endian operands of DATA_W bits, issues one command
// over valid/ready, and streams ECHO payload bytes out.
// Adds length validation, a drain-on-error path and an inter-byte timeout.
// PARAMETERS
// DATA_W          32     operand width in bits; must be a multiple of 8, 8..64
// MAX_OPERANDS    4      operand slots; ALU packets carry 2..MAX_OPERANDS operands
// TIMEOUT_CYCLES  100000 idle clocks allowed between bytes inside a packet; 0 disables
// PORTS
// clk             in   1                  clock
// rst             in   1                  reset
// rx_data_i       in   8                  received byte
// rx_valid_i      in   1                  rx_data_i valid
// rx_ready_o      out  1                  parser accepts byte (beat = valid & ready)
// cmd_opcode_o    out  8                  latched opcode
// cmd_count_o     out  $clog2(MAX_OPERANDS+1)  number of operands received
// cmd_operands_o  out  MAX_OPERANDS*DATA_W     operand j at [j*DATA_W +: DATA_W]; unused slots 0
// cmd_valid_o     out  1                  command valid; held until cmd_ready_i
// cmd_ready_i     in   1                  ALU accepts command
// echo_data_o     out  8                  ECHO payload byte
// echo_valid_o    out  1                  echo_data_o valid
// echo_ready_i    in   1                  TX accepts echo byte
// err_o           out  1                  one-cycle error pulse
// err_code_o      out  2                  0 BAD_OPCODE, 1 BAD_LEN, 2 TIMEOUT, 3 TOO_MANY; held until next error
// BEHAVIOUR
// - Reset: rst is synchronous, active-high; clock is clk.
// - Reset values: state OPCODE. All outputs 0, including rx_ready_o while rst is high.
//   Operand array, counters and err_code_o are cleared. rst mid-packet discards everything.
// - Opcodes: ECHO 8'hEC, ADD 8'hA0, MUL 8'hA1, DIV 8'hA2. LEN counts all bytes, header included.
// - States and transitions; every transition happens on an accepted beat unless stated:
//   OPCODE: rx_ready_o=1. A known opcode is latched -> RESERVED.
//     An unknown opcode is dropped: err BAD_OPCODE, stay in OPCODE.
//   RESERVED: byte discarded -> LEN_LO.
//   LEN_LO: byte latched as LEN[7:0] -> LEN_HI.
//   LEN_HI: LEN[15:8] latched; PAY = LEN-4, computed in 17 bits so an underflow is visible.
//     LEN<4: err BAD_LEN -> OPCODE.
//     ECHO with PAY=0 -> OPCODE, no output. ECHO with PAY>0 -> ECHO.
//     ALU op: PAY not a multiple of DATA_W/8, or fewer than 2 operands: err BAD_LEN -> DRAIN.
//     ALU op with more than MAX_OPERANDS operands: err TOO_MANY -> DRAIN.
//     Otherwise -> OPERANDS.
//   OPERANDS: rx_ready_o=1. Byte k of operand j is written to bits [8k+7:8k] of slot j.
//     The last payload byte -> ISSUE.
//   ISSUE: rx_ready_o=0 and cmd_valid_o=1, starting the cycle after the last byte (latency 1).
//     Outputs stay stable until cmd_ready_i. On the handshake: slots clear -> OPCODE.
//     A byte offered in the handshake cycle is accepted the following cycle.
//   ECHO: combinational pass-through. echo_valid_o=rx_valid_i, rx_ready_o=echo_ready_i.
//     After the PAY-th beat -> OPCODE.
//   DRAIN: rx_ready_o=1. Discards the remaining PAY bytes, then -> OPCODE.
//     If PAY=0, go to OPCODE the next cycle.
// - Timeout: the counter clears on every accepted beat and while in OPCODE or ISSUE.
//   In ECHO it counts only while rx_valid_i=0; backpressure from echo_ready_i never times out.
//   Reaching TIMEOUT_CYCLES: err TIMEOUT, partial operands dropped, -> OPCODE.
// - Byte counter is 16 bits and never wraps: a packet ends at exactly PAY payload bytes.
// - err_o is asserted in the same cycle as the beat (or timeout) that causes the error.
// STRUCTURE
// - config_pkg: add parser_state_e (OPCODE, RESERVED, LEN_LO, LEN_HI, OPERANDS, ISSUE,
//   ECHO, DRAIN), the opcode localparams and the parser_err_e error-code enum.
// - Sub-module: uart_rx_watchdog, a parametrised idle counter (clear, enable, expired).
// TESTING
// - ADD: A0 00 0C 00 01 00 00 00 02 00 00 00 -> cmd_valid_o, opcode A0, count 2,
//   op0=1, op1=2.
// - ECHO: EC 00 07 00 61 62 63, echo_ready_i low every other cycle -> 61 62 63 out in order,
//   no loss, no timeout.
// - Bad opcode 55 then a valid MUL packet -> err BAD_OPCODE once; the MUL is issued correctly.
// - ADD with LEN=0B (7 payload bytes) -> err BAD_LEN. All 7 bytes drained; the next packet
//   parses normally.
// - A0 00 then idle for TIMEOUT_CYCLES -> err TIMEOUT and state OPCODE.
//   rst asserted mid-OPERANDS -> all outputs are 0.
// - Full ADD packet with cmd_ready_i held low for 20 cycles -> rx_ready_o=0 and outputs stable.
//   Release -> exactly one handshake.

Source files
------------

// File: rtl/uart_packet_parser_pkg.sv
// Shared types and constants for the UART packet parser.
package uart_packet_parser_pkg;

    typedef enum logic [2:0] {
        ST_OPCODE   = 3'd0,
        ST_RESERVED = 3'd1,
        ST_LEN_LO   = 3'd2,
        ST_LEN_HI   = 3'd3,
        ST_OPERANDS = 3'd4,
        ST_ISSUE    = 3'd5,
        ST_ECHO     = 3'd6,
        ST_DRAIN    = 3'd7
    } parser_state_e;

    typedef enum logic [1:0] {
        ERR_BAD_OPCODE = 2'd0,
        ERR_BAD_LEN    = 2'd1,
        ERR_TIMEOUT    = 2'd2,
        ERR_TOO_MANY   = 2'd3
    } parser_err_e;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'hA1;
    localparam logic [7:0] OP_DIV  = 8'hA2;

    // Header is opcode, reserved, len_lo, len_hi.
    localparam int unsigned HDR_BYTES = 4;

    // True for opcodes that produce an ALU command.
    function automatic logic is_alu_op(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/uart_packet_parser_watchdog.sv
// Inter-byte idle counter: flags the LIMIT-th consecutive enabled idle cycle.
module uart_rx_watchdog #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt;

    // LIMIT of zero disables the watchdog entirely.
    assign expired_c = (LIMIT != 0) && enable && !clear && (cnt == CNT_W'(LIMIT - 1));

    // Count enabled idle cycles; hold while disabled, restart on clear or expiry.
    always_ff @(posedge clk) begin
        if (rst || clear || expired_c) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_packet_parser.sv
// Packet front-end: parses header, assembles ALU operands, streams ECHO payload.
module uart_packet_parser
    import uart_packet_parser_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_OPERANDS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [7:0]                            rx_data_i,
    input  logic                                  rx_valid_i,
    output logic                                  rx_ready_o,
    output logic [7:0]                            cmd_opcode_o,
    output logic [$clog2(MAX_OPERANDS+1)-1:0]     cmd_count_o,
    output logic [MAX_OPERANDS*DATA_W-1:0]        cmd_operands_o,
    output logic                                  cmd_valid_o,
    input  logic                                  cmd_ready_i,
    output logic [7:0]                            echo_data_o,
    output logic                                  echo_valid_o,
    input  logic                                  echo_ready_i,
    output logic                                  err_o,
    output logic [1:0]                            err_code_o
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(MAX_OPERANDS + 1);
    localparam int unsigned SLOT_W = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;
    localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    parser_state_e state_q, state_d;

    logic [7:0]                           opcode_q;
    logic [7:0]                           len_lo_q;
    logic [15:0]                          pay_q;
    logic [15:0]                          byte_cnt_q;
    logic [SLOT_W-1:0]                    slot_q;
    logic [BIDX_W-1:0]                    bidx_q;
    logic [CNT_W-1:0]                     count_q;
    logic [MAX_OPERANDS-1:0][DATA_W-1:0]  operands_q;
    parser_err_e                          err_code_q;

    logic        rx_ready_c;
    logic        beat_c;
    logic        wd_enable_c;
    logic        wd_clear_c;
    logic        wd_expired_c;
    logic        last_c;
    logic        err_c;
    parser_err_e err_code_c;

    logic [15:0] len_c;
    logic [16:0] pay17_c;
    logic [15:0] pay_c;
    logic [15:0] n_ops_c;
    logic [15:0] rem_c;

    // Length decode for the LEN_HI beat; bit 16 of pay17_c exposes LEN < 4.
    always_comb begin
        len_c   = {rx_data_i, len_lo_q};
        pay17_c = {1'b0, len_c} - 17'(HDR_BYTES);
        pay_c   = pay17_c[15:0];
        n_ops_c = pay_c / 16'(BYTES);
        rem_c   = pay_c % 16'(BYTES);
    end

    // Byte acceptance and watchdog control from the current state.
    always_comb begin
        rx_ready_c = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_OPCODE, ST_RESERVED, ST_LEN_LO,
                ST_LEN_HI, ST_OPERANDS:  rx_ready_c = 1'b1;
                ST_ECHO:                 rx_ready_c = echo_ready_i;
                ST_DRAIN:                rx_ready_c = (pay_q != 16'd0);
                default:                 rx_ready_c = 1'b0;
            endcase
        end
        beat_c      = rx_valid_i && rx_ready_c;
        wd_clear_c  = beat_c || (state_q == ST_OPCODE) || (state_q == ST_ISSUE);
        wd_enable_c = !rst && (state_q != ST_OPCODE) && (state_q != ST_ISSUE)
                      && !((state_q == ST_ECHO) && rx_valid_i);
        last_c      = (byte_cnt_q == (pay_q - 16'd1));
    end

    uart_rx_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear     (wd_clear_c),
        .enable    (wd_enable_c),
        .expired_c (wd_expired_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OPCODE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and error decode.
    always_comb begin
        state_d    = state_q;
        err_c      = 1'b0;
        err_code_c = ERR_BAD_OPCODE;
        if (wd_expired_c) begin
            err_c      = 1'b1;
            err_code_c = ERR_TIMEOUT;
            state_d    = ST_OPCODE;
        end else begin
            unique case (state_q)
                ST_OPCODE: begin
                    if (beat_c) begin
                        if (is_alu_op(rx_data_i) || (rx_data_i == OP_ECHO)) begin
                            state_d = ST_RESERVED;
                        end else begin
                            err_c      = 1'b1;
                            err_code_c = ERR_BAD_OPCODE;
                        end
                    end
                end
                ST_RESERVED: if (beat_c) state_d = ST_LEN_LO;
                ST_LEN_LO:   if (beat_c) state_d = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (beat_c) begin
                        if (pay17_c[16]) begin
                            err_c      = 1'b1;
                            err_code_c = ERR_BAD_LEN;
                            state_d    = ST_OPCODE;
                        end else if (opcode_q == OP_ECHO) begin
                            state_d = (pay_c == 16'd0) ? ST_OPCODE : ST_ECHO;
                        end else if ((rem_c != 16'd0) || (n_ops_c < 16'd2)) begin
                            err_c      = 1'b1;
                            err_code_c = ERR_BAD_LEN;
                            state_d    = ST_DRAIN;
                        end else if (n_ops_c > 16'(MAX_OPERANDS)) begin
                            err_c      = 1'b1;
                            err_code_c = ERR_TOO_MANY;
                            state_d    = ST_DRAIN;
                        end else begin
                            state_d = ST_OPERANDS;
                        end
                    end
                end
                ST_OPERANDS: if (beat_c && last_c) state_d = ST_ISSUE;
                ST_ISSUE:    if (cmd_ready_i) state_d = ST_OPCODE;
                ST_ECHO:     if (beat_c && last_c) state_d = ST_OPCODE;
                ST_DRAIN: begin
                    if (pay_q == 16'd0) begin
                        state_d = ST_OPCODE;
                    end else if (beat_c && last_c) begin
                        state_d = ST_OPCODE;
                    end
                end
                default: state_d = ST_OPCODE;
            endcase
        end
    end

    // Header latches, payload counters and operand assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q   <= '0;
            len_lo_q   <= '0;
            pay_q      <= '0;
            byte_cnt_q <= '0;
            slot_q     <= '0;
            bidx_q     <= '0;
            count_q    <= '0;
            operands_q <= '0;
            err_code_q <= ERR_BAD_OPCODE;
        end else begin
            if (err_c) begin
                err_code_q <= err_code_c;
            end
            if (wd_expired_c) begin
                operands_q <= '0;
                count_q    <= '0;
            end else begin
                unique case (state_q)
                    ST_OPCODE: begin
                        if (beat_c && (state_d == ST_RESERVED)) opcode_q <= rx_data_i;
                    end
                    ST_LEN_LO: begin
                        if (beat_c) len_lo_q <= rx_data_i;
                    end
                    ST_LEN_HI: begin
                        if (beat_c) begin
                            pay_q      <= pay_c;
                            byte_cnt_q <= '0;
                            slot_q     <= '0;
                            bidx_q     <= '0;
                            if (state_d == ST_OPERANDS) count_q <= CNT_W'(n_ops_c);
                        end
                    end
                    ST_OPERANDS: begin
                        if (beat_c) begin
                            operands_q[slot_q][{bidx_q, 3'b000} +: 8] <= rx_data_i;
                            byte_cnt_q <= byte_cnt_q + 16'd1;
                            if (bidx_q == BIDX_W'(BYTES - 1)) begin
                                bidx_q <= '0;
                                slot_q <= slot_q + SLOT_W'(1);
                            end else begin
                                bidx_q <= bidx_q + BIDX_W'(1);
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (cmd_ready_i) begin
                            operands_q <= '0;
                            count_q    <= '0;
                        end
                    end
                    ST_ECHO, ST_DRAIN: begin
                        if (beat_c) byte_cnt_q <= byte_cnt_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output drive; everything is forced low while reset is asserted.
    always_comb begin
        rx_ready_o     = rx_ready_c;
        cmd_valid_o    = !rst && (state_q == ST_ISSUE);
        cmd_opcode_o   = rst ? 8'd0 : opcode_q;
        cmd_count_o    = rst ? '0 : count_q;
        cmd_operands_o = rst ? '0 : operands_q;
        echo_valid_o   = !rst && (state_q == ST_ECHO) && rx_valid_i;
        echo_data_o    = (!rst && (state_q == ST_ECHO)) ? rx_data_i : 8'd0;
        err_o          = err_c;
        err_code_o     = rst ? 2'd0 : (err_c ? err_code_c : err_code_q);
    end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: directed packets, decoupled monitor.
module tb_uart_packet_parser;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_OPS = 4;
    localparam int unsigned TO      = 50;

    typedef struct {
        logic [7:0]   op;
        logic [2:0]   cnt;
        logic [127:0] ops;
    } cmd_t;

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   cmd_opcode;
    logic [2:0]   cmd_count;
    logic [127:0] cmd_operands;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   echo_data;
    logic         echo_valid;
    logic         echo_ready;
    logic         err;
    logic [1:0]   err_code;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_echo[$];
    logic [1:0] exp_err[$];
    logic [7:0] pkt[$];

    int  tests;
    int  fails;
    int  hs_count;
    int  hs_before;
    bit  echo_toggle;

    uart_packet_parser #(
        .DATA_W         (DATA_W),
        .MAX_OPERANDS   (MAX_OPS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .rx_ready_o     (rx_ready),
        .cmd_opcode_o   (cmd_opcode),
        .cmd_count_o    (cmd_count),
        .cmd_operands_o (cmd_operands),
        .cmd_valid_o    (cmd_valid),
        .cmd_ready_i    (cmd_ready),
        .echo_data_o    (echo_data),
        .echo_valid_o   (echo_valid),
        .echo_ready_i   (echo_ready),
        .err_o          (err),
        .err_code_o     (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a transfer.
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cmd_valid && cmd_ready) begin
                    hs_count++;
                    if (exp_cmd.size() == 0) begin
                        check("unexpected_cmd", 128'(cmd_opcode), 128'hFFFF);
                    end else begin
                        e = exp_cmd.pop_front();
                        check("cmd_opcode", 128'(cmd_opcode), 128'(e.op));
                        check("cmd_count", 128'(cmd_count), 128'(e.cnt));
                        check("cmd_operands", cmd_operands, e.ops);
                    end
                end
                if (echo_valid && echo_ready) begin
                    if (exp_echo.size() == 0) check("unexpected_echo", 128'(echo_data), 128'h1FF);
                    else check("echo_data", 128'(echo_data), 128'(exp_echo.pop_front()));
                end
                if (err) begin
                    if (exp_err.size() == 0) check("unexpected_err", 128'(err_code), 128'h7);
                    else check("err_code", 128'(err_code), 128'(exp_err.pop_front()));
                end
            end
        end
    end

    // Echo sink: toggles ready every cycle when requested.
    initial begin
        echo_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            echo_ready = echo_toggle ? ~echo_ready : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  acc;
        n = 0;
        acc = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("byte_accept", 128'(0), 128'(1));
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_echo.size() != 0 || exp_err.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 128'(exp_cmd.size() + exp_echo.size() + exp_err.size()), 128'(0));
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_rx_ready"}, 128'(rx_ready), 128'(0));
        check({tag, "_cmd_valid"}, 128'(cmd_valid), 128'(0));
        check({tag, "_cmd_opcode"}, 128'(cmd_opcode), 128'(0));
        check({tag, "_cmd_count"}, 128'(cmd_count), 128'(0));
        check({tag, "_cmd_operands"}, cmd_operands, 128'(0));
        check({tag, "_echo_valid"}, 128'(echo_valid), 128'(0));
        check({tag, "_echo_data"}, 128'(echo_data), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(0));
        check({tag, "_err_code"}, 128'(err_code), 128'(0));
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        hs_count    = 0;
        echo_toggle = 1'b0;
        rst         = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        cmd_ready   = 1'b1;

        // Reset state
        idle(3);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 128'(rx_ready), 128'(1));
        @(posedge clk);
        #1;

        // Basic ADD
        exp_cmd.push_back('{8'hA0, 3'd2, {32'd0, 32'd0, 32'd2, 32'd1}});
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_drain("add_drain", 50);

        // ECHO with echo backpressure every other cycle
        echo_toggle = 1'b1;
        exp_echo.push_back(8'h61);
        exp_echo.push_back(8'h62);
        exp_echo.push_back(8'h63);
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h61, 8'h62, 8'h63};
        send_pkt();
        wait_drain("echo_drain", 50);
        echo_toggle = 1'b0;
        idle(2);

        // Bad opcode then 3-operand MUL
        exp_err.push_back(2'd0);
        exp_cmd.push_back('{8'hA1, 3'd3, {32'd0, 32'd7, 32'd6, 32'd5}});
        pkt = '{8'h55, 8'hA1, 8'h00, 8'h10, 8'h00,
                8'h05, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_drain("badop_drain", 50);

        // Misaligned ADD is drained, next DIV parses normally
        exp_err.push_back(2'd1);
        exp_cmd.push_back('{8'hA2, 3'd2, {32'd0, 32'd0, 32'd3, 32'd9}});
        pkt = '{8'hA0, 8'h00, 8'h0B, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'hA2, 8'h00, 8'h0C, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_drain("badlen_drain", 50);
        @(negedge clk);
        check("err_code_held_badlen", 128'(err_code), 128'(1));
        @(posedge clk);
        #1;

        // Five operands: TOO_MANY, 20 bytes drained; then ECHO with empty payload
        exp_err.push_back(2'd3);
        pkt = '{8'hA0, 8'h00, 8'h18, 8'h00};
        for (int i = 0; i < 20; i++) pkt.push_back(8'(i + 1));
        pkt.push_back(8'hEC);
        pkt.push_back(8'h00);
        pkt.push_back(8'h04);
        pkt.push_back(8'h00);
        send_pkt();
        wait_drain("toomany_drain", 50);
        idle(3);
        @(negedge clk);
        check("err_code_held_toomany", 128'(err_code), 128'(3));
        @(posedge clk);
        #1;

        // LEN below header size, then one-byte ECHO
        exp_err.push_back(2'd1);
        exp_echo.push_back(8'h7E);
        pkt = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
        send_pkt();
        wait_drain("shortlen_drain", 50);

        // Timeout in the header
        exp_err.push_back(2'd2);
        pkt = '{8'hA0, 8'h00};
        send_pkt();
        wait_drain("timeout_hdr", TO + 20);
        @(negedge clk);
        check("err_code_timeout", 128'(err_code), 128'(2));
        check("ready_after_timeout", 128'(rx_ready), 128'(1));
        @(posedge clk);
        #1;

        // Timeout mid-operands drops partial data; next packet sees clean slots
        exp_err.push_back(2'd2);
        pkt = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'hAA};
        send_pkt();
        wait_drain("timeout_ops", TO + 20);
        exp_cmd.push_back('{8'hA0, 3'd2, {32'd0, 32'd0, 32'd4, 32'd3}});
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_drain("after_timeout_add", 50);

        // Reset in the middle of OPERANDS
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22};
        send_pkt();
        rst = 1'b1;
        idle(1);
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cmd.push_back('{8'hA1, 3'd2, {32'd0, 32'd0, 32'h0000_0100, 32'h0000_00FF}});
        pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        send_pkt();
        wait_drain("after_rst_mul", 50);

        // Command stalled for 20 cycles, then exactly one handshake
        cmd_ready = 1'b0;
        hs_before = hs_count;
        exp_cmd.push_back('{8'hA0, 3'd2, {32'd0, 32'd0, 32'h5566_7788, 32'h1122_3344}});
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        send_pkt();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("stall_valid", 128'(cmd_valid), 128'(1));
            check("stall_rx_ready", 128'(rx_ready), 128'(0));
            check("stall_operands", cmd_operands, {64'd0, 32'h5566_7788, 32'h1122_3344});
        end
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        wait_drain("stall_release", 20);
        idle(5);
        check("single_handshake", 128'(hs_count - hs_before), 128'(1));
        @(negedge clk);
        check("idle_cmd_valid", 128'(cmd_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog for the whole run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
